// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED-sharing arbiter.
package led_arb_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, GAP} arb_state_e;

  localparam int         LED_IDX_W  = 3;
  localparam logic [2:0] ENABLE_ON  = 3'b100;
  localparam logic [2:0] ENABLE_OFF = 3'b000;
endpackage

// File: rtl/led_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping to 0.
module led_rr_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             any,
  output logic [PTR_W-1:0] winner,
  output logic [NREQ-1:0]  onehot
);
  always_comb begin
    int p;
    p      = 0;
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    // scan from the far end so the candidate closest to rr_ptr is written last and wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      p = int'(rr_ptr) + k;
      if (p >= NREQ) p = p - NREQ;
      if (req[PTR_W'(p)]) begin
        any    = 1'b1;
        winner = PTR_W'(p);
      end
    end
    if (any) onehot[winner] = 1'b1;
  end
endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin sequencer sharing one LED decoder among NREQ requesters.
// Optional LED_ARB_BLINK_EN: enable blinks with BLINK_HALF half-period during SHOW.
module led_share_arbiter
  import led_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DWELL      = 8,
  parameter int BLINK_HALF = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*3-1:0]      idx,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic [LED_IDX_W-1:0]   switch,
  output logic [2:0]             enable
);
  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= 8) && (DWELL >= 1) && (BLINK_HALF >= 1);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("led_share_arbiter: illegal parameter set");
    end
  endgenerate

  arb_state_e                          state;
  logic [PTR_W-1:0]                    rr_ptr, win_q;
  logic [CNT_W-1:0]                    cnt;
  logic [NREQ-1:0][LED_IDX_W-1:0]      idx_v;
  logic                                any;
  logic [PTR_W-1:0]                    winner;
  logic [NREQ-1:0]                     onehot;

  assign idx_v = idx;

`ifdef LED_ARB_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic [BW-1:0] bcnt;
`endif

  led_rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (any),
    .winner (winner),
    .onehot (onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      win_q  <= '0;
      cnt    <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      switch <= '0;
      enable <= ENABLE_OFF;
`ifdef LED_ARB_BLINK_EN
      bcnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE, GAP: begin
          done <= '0;
          if (any) begin
            state  <= SHOW;
            busy   <= 1'b1;
            gnt    <= onehot;
            win_q  <= winner;
            switch <= idx_v[winner];
            enable <= ENABLE_ON;
            cnt    <= CNT_W'(DWELL - 1);
`ifdef LED_ARB_BLINK_EN
            bcnt   <= '0;
`endif
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
            gnt    <= '0;
            enable <= ENABLE_OFF;
          end
        end
        SHOW: begin
          // dwell expiry or early release by the owner both end the grant
          if (cnt == '0 || !req[win_q]) begin
            state  <= GAP;
            gnt    <= '0;
            done   <= gnt;
            enable <= ENABLE_OFF;
            rr_ptr <= (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
`ifdef LED_ARB_BLINK_EN
            if (bcnt == BW'(BLINK_HALF - 1)) begin
              bcnt   <= '0;
              enable <= enable ^ ENABLE_ON;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_share_arbiter.sv
// Randomized bench for led_share_arbiter against a grant/dwell reference model.
module tb_led_share_arbiter;
  import led_arb_pkg::*;

  localparam int NREQ = 4, DWELL = 8, BLINK_HALF = 2;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*3-1:0]  idx = '0;
  logic [NREQ-1:0]    gnt, done;
  logic               busy;
  logic [2:0]         switch, enable;

  always #5 clk = ~clk;

  led_share_arbiter #(.NREQ(NREQ), .DWELL(DWELL), .BLINK_HALF(BLINK_HALF)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .idx(idx),
    .gnt(gnt), .done(done), .busy(busy), .switch(switch), .enable(enable)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // model: mode 0 idle, 1 showing, 2 gap; m_el = SHOW cycles already elapsed
  int              m_st, m_own, m_el, m_ptr;
  logic [2:0]      m_sw;
  logic [NREQ-1:0] m_done;

  function automatic void model_reset();
    m_st = 0; m_own = 0; m_el = 0; m_ptr = 0; m_sw = '0; m_done = '0;
  endfunction

  function automatic bit blink_on(int e);
`ifdef LED_ARB_BLINK_EN
    return ((e / BLINK_HALF) % 2) == 0;
`else
    return (e >= 0);
`endif
  endfunction

  function automatic void model_next();
    int w;
    w = -1;
    if (m_st == 1) begin
      if (m_el == DWELL - 1 || !req[m_own]) begin
        m_st = 2; m_done = '0; m_done[m_own] = 1'b1; m_ptr = (m_own + 1) % NREQ;
      end else m_el++;
    end else begin
      m_done = '0;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_st = 1; m_own = w; m_el = 0; m_sw = idx[3*w +: 3];
      end else m_st = 0;
    end
  endfunction

  task automatic check_outputs();
    logic [NREQ-1:0] eg;
    eg = '0;
    if (m_st == 1) eg[m_own] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("switch", 32'(switch), 32'(m_sw));
    chk("enable", 32'(enable), (m_st == 1 && blink_on(m_el)) ? 32'h4 : 32'h0);
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'h1);
    chk("enable_legal", 32'(enable == 3'b100 || enable == 3'b000), 32'h1);
  endtask

  task automatic tick();
    model_next();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_switch"}, 32'(switch), 32'h0);
    chk({tag, "_enable"}, 32'(enable), 32'h0);
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    logic [NREQ-1:0] prev;
    int gnt_cnt, on_cnt, exp_on;
    bit saw_done, did_rst;

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // all requesters held: strict rotation 0,1,2,3,0
    exp_order = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    idx = {3'd3, 3'd2, 3'd1, 3'd0};
    prev = '0;
    repeat (5 * (DWELL + 1)) begin
      tick();
      if (gnt != '0 && prev == '0)
        for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
      prev = gnt;
    end
    chk("rr_ngrants", 32'(order.size() >= 5), 32'h1);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_order%0d", k), (k < order.size()) ? 32'(order[k]) : 32'hff, 32'(exp_order[k]));
    req = '0;
    repeat (3) tick();

    // single requester 0 with index 5, full dwell
    req = 4'b0001;
    idx = '0;
    idx[2:0] = 3'd5;
    gnt_cnt = 0; on_cnt = 0; saw_done = 1'b0;
    exp_on = 0;
    for (int e = 0; e < DWELL; e++) if (blink_on(e)) exp_on++;
    repeat (DWELL + 4) begin
      tick();
      if (gnt[0]) begin
        gnt_cnt++;
        chk("single_switch", 32'(switch), 32'h5);
      end
      if (enable == ENABLE_ON) on_cnt++;
      if (done[0]) begin saw_done = 1'b1; req = '0; end
    end
    chk("single_gnt_cycles", 32'(gnt_cnt), 32'(DWELL));
    chk("single_on_cycles", 32'(on_cnt), 32'(exp_on));
    chk("single_done", 32'(saw_done), 32'h1);

    // early release: req[2] dropped after 3 SHOW cycles
    req = 4'b0100;
    idx[8:6] = 3'd6;
    repeat (3) tick();
    req = '0;
    tick();
    chk("early_done", 32'(done), 32'h4);
    chk("early_enable", 32'(enable), 32'h0);
    tick();
    chk("early_idle_busy", 32'(busy), 32'h0);

    // randomized traffic with one asynchronous reset in the middle of a grant
    did_rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (!did_rst && c > 200 && m_st == 1 && m_el == 3) begin
        did_rst = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midshow_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            idx[3*i +: 3] = 3'($urandom_range(7));
          end
        end else if (m_done[i]) begin
          if ($urandom_range(1) == 1) req[i] = 1'b0;
        end else if (m_st == 1 && m_own == i && $urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          idx[3*i +: 3] = 3'($urandom_range(7));
        end
      end
    end
    chk("midshow_reset_hit", 32'(did_rst), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
